// File: rtl/sp_req_arbiter.sv
// sp_req_arbiter
//   Merges scratchpad requests from the MLS and GEMM functional units into
//   the single scratchpad request FIFO. Each source has a one-entry holding
//   register; held packets are arbitrated round-robin, stalled by FIFO
//   backpressure, and speculative entries are dropped on flush.
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   mls_valid / mls_ready     MLS handshake
//   mls_ls_in                 01 load, 10 store, 00/11 dropped
//   mls_rd_in, mls_rs_in,
//   mls_imm_in, mls_spec      MLS request fields
//   gemm_valid / gemm_ready   GEMM handshake
//   gemm_new_weight_in,
//   gemm_rs{1,2,3}_in,
//   gemm_rd_in, gemm_spec     GEMM request fields
//   flush                     drop all speculative work
//   sp_full                   FIFO full
//   sp_wen, sp_wdata          FIFO push and packet
//   busy                      any holding register occupied
module sp_req_arbiter #(
  parameter int unsigned MAT_W  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PKT_W  = 2 + MAT_W + ADDR_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              mls_valid,
  output logic              mls_ready,
  input  logic [1:0]        mls_ls_in,
  input  logic [MAT_W-1:0]  mls_rd_in,
  input  logic [ADDR_W-1:0] mls_rs_in,
  input  logic [ADDR_W-1:0] mls_imm_in,
  input  logic              mls_spec,
  input  logic              gemm_valid,
  output logic              gemm_ready,
  input  logic              gemm_new_weight_in,
  input  logic [MAT_W-1:0]  gemm_rs1_in,
  input  logic [MAT_W-1:0]  gemm_rs2_in,
  input  logic [MAT_W-1:0]  gemm_rs3_in,
  input  logic [MAT_W-1:0]  gemm_rd_in,
  input  logic              gemm_spec,
  input  logic              flush,
  input  logic              sp_full,
  output logic              sp_wen,
  output logic [PKT_W-1:0]  sp_wdata,
  output logic              busy
);

  // Zero padding between the weight-reload bit and the four register fields.
  localparam int unsigned GPAD = PKT_W - 3 - 4 * MAT_W;

  typedef enum logic {LAST_MLS, LAST_GEMM} rr_t;

  rr_t               last_q;
  logic              hold_mls_valid, hold_mls_spec;
  logic              hold_gemm_valid, hold_gemm_spec;
  logic [PKT_W-1:0]  hold_mls_pkt, hold_gemm_pkt;

  logic [ADDR_W-1:0] mls_addr;
  logic [PKT_W-1:0]  mls_pkt, gemm_pkt;
  logic              elig_mls, elig_gemm;
  logic              grant_mls, grant_gemm;
  logic              clr_mls, clr_gemm;
  logic              load_mls, load_gemm;

  assign mls_addr = mls_rs_in + mls_imm_in;
  assign mls_pkt  = {mls_ls_in, mls_rd_in, mls_addr};
  assign gemm_pkt = {2'b11, gemm_new_weight_in, {GPAD{1'b0}},
                     gemm_rs1_in, gemm_rs2_in, gemm_rs3_in, gemm_rd_in};

  // Entries killed by this cycle's flush.
  assign clr_mls  = flush && hold_mls_valid  && hold_mls_spec;
  assign clr_gemm = flush && hold_gemm_valid && hold_gemm_spec;

  assign elig_mls  = hold_mls_valid  && !clr_mls;
  assign elig_gemm = hold_gemm_valid && !clr_gemm;

  always_comb begin
    grant_mls  = 1'b0;
    grant_gemm = 1'b0;
    if (!sp_full) begin
      if (elig_mls && elig_gemm) begin
        grant_mls  = (last_q == LAST_GEMM);
        grant_gemm = (last_q == LAST_MLS);
      end else begin
        grant_mls  = elig_mls;
        grant_gemm = elig_gemm;
      end
    end
  end

  assign sp_wen   = grant_mls || grant_gemm;
  assign sp_wdata = grant_mls  ? hold_mls_pkt  :
                    grant_gemm ? hold_gemm_pkt : '0;

  // A register emptied by flush can accept immediately.
  assign mls_ready  = !hold_mls_valid  || grant_mls  || clr_mls;
  assign gemm_ready = !hold_gemm_valid || grant_gemm || clr_gemm;
  assign busy       = hold_mls_valid || hold_gemm_valid;

  // Invalid MLS opcodes and speculative requests arriving during a flush
  // complete the handshake but are never stored.
  assign load_mls  = mls_valid && mls_ready && (^mls_ls_in) && !(flush && mls_spec);
  assign load_gemm = gemm_valid && gemm_ready && !(flush && gemm_spec);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_q          <= LAST_GEMM;
      hold_mls_valid  <= 1'b0;
      hold_mls_spec   <= 1'b0;
      hold_mls_pkt    <= '0;
      hold_gemm_valid <= 1'b0;
      hold_gemm_spec  <= 1'b0;
      hold_gemm_pkt   <= '0;
    end else begin
      if (grant_mls)
        last_q <= LAST_MLS;
      else if (grant_gemm)
        last_q <= LAST_GEMM;

      if (load_mls) begin
        hold_mls_valid <= 1'b1;
        hold_mls_spec  <= mls_spec;
        hold_mls_pkt   <= mls_pkt;
      end else if (grant_mls || clr_mls) begin
        hold_mls_valid <= 1'b0;
      end

      if (load_gemm) begin
        hold_gemm_valid <= 1'b1;
        hold_gemm_spec  <= gemm_spec;
        hold_gemm_pkt   <= gemm_pkt;
      end else if (grant_gemm || clr_gemm) begin
        hold_gemm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sp_req_arbiter.sv
module tb_sp_req_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        mls_valid, mls_ready, mls_spec;
  logic [1:0]  mls_ls_in;
  logic [3:0]  mls_rd_in;
  logic [31:0] mls_rs_in, mls_imm_in;
  logic        gemm_valid, gemm_ready, gemm_new_weight_in, gemm_spec;
  logic [3:0]  gemm_rs1_in, gemm_rs2_in, gemm_rs3_in, gemm_rd_in;
  logic        flush, sp_full, sp_wen, busy;
  logic [37:0] sp_wdata;

  int total = 0;
  int bad   = 0;

  localparam logic [37:0] PKT_T2   = 38'h13_0000_0010;
  localparam logic [37:0] PKT_MLS3 = 38'h25_0000_0104;
  localparam logic [37:0] PKT_G3   = 38'h38_0000_1234;
  localparam logic [37:0] PKT_G5   = 38'h30_0000_ABCD;

  always #5 CLK = ~CLK;

  sp_req_arbiter #(.MAT_W(4), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .mls_valid(mls_valid), .mls_ready(mls_ready), .mls_ls_in(mls_ls_in),
    .mls_rd_in(mls_rd_in), .mls_rs_in(mls_rs_in), .mls_imm_in(mls_imm_in),
    .mls_spec(mls_spec),
    .gemm_valid(gemm_valid), .gemm_ready(gemm_ready),
    .gemm_new_weight_in(gemm_new_weight_in),
    .gemm_rs1_in(gemm_rs1_in), .gemm_rs2_in(gemm_rs2_in),
    .gemm_rs3_in(gemm_rs3_in), .gemm_rd_in(gemm_rd_in), .gemm_spec(gemm_spec),
    .flush(flush), .sp_full(sp_full), .sp_wen(sp_wen), .sp_wdata(sp_wdata),
    .busy(busy)
  );

  task automatic idle_inputs();
    mls_valid = 0; mls_spec = 0; mls_ls_in = 2'b00; mls_rd_in = 0;
    mls_rs_in = 0; mls_imm_in = 0;
    gemm_valid = 0; gemm_spec = 0; gemm_new_weight_in = 0;
    gemm_rs1_in = 0; gemm_rs2_in = 0; gemm_rs3_in = 0; gemm_rd_in = 0;
    flush = 0; sp_full = 0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    nRST = 0;
    idle_inputs();
    @(negedge CLK);
    nRST = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 0;
    #12;
    total++; if (sp_wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%0b exp=0", sp_wen); end
    total++; if (sp_wdata !== 38'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", sp_wdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (mls_ready !== 1'b1) begin bad++; $display("FAIL reset_mls_ready got=%0b exp=1", mls_ready); end
    total++; if (gemm_ready !== 1'b1) begin bad++; $display("FAIL reset_gemm_ready got=%0b exp=1", gemm_ready); end
    @(negedge CLK);
    nRST = 1;
    @(negedge CLK); #1;
    total++; if (sp_wen !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle wen=%0b busy=%0b exp 0/0", sp_wen, busy); end
  endtask

  task automatic test_mls_load();
    @(negedge CLK);
    mls_valid = 1; mls_ls_in = 2'b01; mls_rd_in = 4'd3;
    mls_rs_in = 32'hFFFF_FFF0; mls_imm_in = 32'h20;
    #1;
    total++; if (mls_ready !== 1'b1 || sp_wen !== 1'b0) begin bad++; $display("FAIL t2_accept ready=%0b wen=%0b exp 1/0", mls_ready, sp_wen); end
    @(negedge CLK);
    mls_valid = 0;
    #1;
    total++; if (sp_wen !== 1'b1) begin bad++; $display("FAIL t2_wen got=%0b exp=1", sp_wen); end
    total++; if (sp_wdata !== PKT_T2) begin bad++; $display("FAIL t2_wdata got=%h exp=%h", sp_wdata, PKT_T2); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t2_busy got=%0b exp=1", busy); end
    @(negedge CLK); #1;
    total++; if (sp_wen !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL t2_drain wen=%0b busy=%0b exp 0/0", sp_wen, busy); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    mls_valid = 1; mls_ls_in = 2'b10; mls_rd_in = 4'd5;
    mls_rs_in = 32'h100; mls_imm_in = 32'h4;
    gemm_valid = 1; gemm_new_weight_in = 1;
    gemm_rs1_in = 4'd1; gemm_rs2_in = 4'd2; gemm_rs3_in = 4'd3; gemm_rd_in = 4'd4;
    #1;
    total++; if (sp_wen !== 1'b0 || mls_ready !== 1'b1 || gemm_ready !== 1'b1) begin
      bad++; $display("FAIL t3_first wen=%0b mr=%0b gr=%0b exp 0/1/1", sp_wen, mls_ready, gemm_ready); end
    for (int i = 0; i < 4; i++) begin
      logic [37:0] exp_pkt;
      logic        exp_m;
      exp_m   = (i % 2 == 0);
      exp_pkt = exp_m ? PKT_MLS3 : PKT_G3;
      @(negedge CLK); #1;
      total++; if (sp_wen !== 1'b1 || sp_wdata !== exp_pkt) begin
        bad++; $display("FAIL t3_grant%0d wen=%0b data=%h exp 1/%h", i, sp_wen, sp_wdata, exp_pkt); end
      total++; if (mls_ready !== exp_m || gemm_ready !== !exp_m) begin
        bad++; $display("FAIL t3_ready%0d mr=%0b gr=%0b exp %0b/%0b", i, mls_ready, gemm_ready, exp_m, !exp_m); end
    end
  endtask

  // Continues from test_round_robin: both registers are held and GEMM was
  // granted last.
  task automatic test_full();
    @(negedge CLK);
    mls_valid = 0; gemm_valid = 0; sp_full = 1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge CLK);
      #1;
      total++; if (sp_wen !== 1'b0 || mls_ready !== 1'b0 || gemm_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL t4_full%0d wen=%0b mr=%0b gr=%0b busy=%0b exp 0/0/0/1", i, sp_wen, mls_ready, gemm_ready, busy); end
    end
    @(negedge CLK);
    sp_full = 0;
    #1;
    total++; if (sp_wen !== 1'b1 || sp_wdata !== PKT_MLS3) begin
      bad++; $display("FAIL t4_drain_mls wen=%0b data=%h exp 1/%h", sp_wen, sp_wdata, PKT_MLS3); end
    @(negedge CLK); #1;
    total++; if (sp_wen !== 1'b1 || sp_wdata !== PKT_G3) begin
      bad++; $display("FAIL t4_drain_gemm wen=%0b data=%h exp 1/%h", sp_wen, sp_wdata, PKT_G3); end
    @(negedge CLK); #1;
    total++; if (sp_wen !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t4_empty wen=%0b busy=%0b exp 0/0", sp_wen, busy); end
  endtask

  task automatic test_flush();
    apply_reset();
    mls_valid = 1; mls_spec = 1; mls_ls_in = 2'b01; mls_rd_in = 4'd7;
    mls_rs_in = 32'h40; mls_imm_in = 32'h8;
    gemm_valid = 1; gemm_spec = 0;
    gemm_rs1_in = 4'hA; gemm_rs2_in = 4'hB; gemm_rs3_in = 4'hC; gemm_rd_in = 4'hD;
    sp_full = 1;
    #1;
    total++; if (mls_ready !== 1'b1 || gemm_ready !== 1'b1 || sp_wen !== 1'b0) begin
      bad++; $display("FAIL t5_capture mr=%0b gr=%0b wen=%0b exp 1/1/0", mls_ready, gemm_ready, sp_wen); end
    @(negedge CLK);
    gemm_valid = 0; flush = 1; mls_imm_in = 32'h10;
    #1;
    total++; if (sp_wen !== 1'b0 || mls_ready !== 1'b1 || gemm_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL t5_flush wen=%0b mr=%0b gr=%0b busy=%0b exp 0/1/0/1", sp_wen, mls_ready, gemm_ready, busy); end
    @(negedge CLK);
    mls_valid = 0; flush = 0; sp_full = 0;
    #1;
    total++; if (sp_wen !== 1'b1 || sp_wdata !== PKT_G5) begin
      bad++; $display("FAIL t5_gemm_only wen=%0b data=%h exp 1/%h", sp_wen, sp_wdata, PKT_G5); end
    total++; if (mls_ready !== 1'b1) begin bad++; $display("FAIL t5_mls_empty mr=%0b exp=1", mls_ready); end
    @(negedge CLK); #1;
    total++; if (sp_wen !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t5_after wen=%0b busy=%0b exp 0/0", sp_wen, busy); end
  endtask

  task automatic test_invalid_ls();
    @(negedge CLK);
    idle_inputs();
    mls_valid = 1; mls_ls_in = 2'b00; mls_rs_in = 32'h55;
    #1;
    total++; if (mls_ready !== 1'b1) begin bad++; $display("FAIL t6_ready00 got=%0b exp=1", mls_ready); end
    @(negedge CLK);
    mls_ls_in = 2'b11;
    #1;
    total++; if (mls_ready !== 1'b1 || sp_wen !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t6_ls11 mr=%0b wen=%0b busy=%0b exp 1/0/0", mls_ready, sp_wen, busy); end
    @(negedge CLK);
    mls_valid = 0;
    #1;
    total++; if (sp_wen !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t6_drop wen=%0b busy=%0b exp 0/0", sp_wen, busy); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    mls_valid = 1; mls_ls_in = 2'b01; mls_rd_in = 4'd0; mls_rs_in = 32'd0; mls_imm_in = 32'd1;
    for (int i = 1; i <= 3; i++) begin
      logic [37:0] exp_pkt;
      exp_pkt = 38'h10_0000_0000 | 38'(i);
      @(negedge CLK);
      if (i < 3) mls_imm_in = 32'(i + 1);
      else mls_valid = 0;
      #1;
      total++; if (sp_wen !== 1'b1 || sp_wdata !== exp_pkt || mls_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d wen=%0b data=%h mr=%0b exp 1/%h/1", i, sp_wen, sp_wdata, mls_ready, exp_pkt); end
    end
    @(negedge CLK); #1;
    total++; if (sp_wen !== 1'b0) begin bad++; $display("FAIL b2b_end wen=%0b exp=0", sp_wen); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    idle_inputs();
    gemm_valid = 1; gemm_rd_in = 4'd9;
    @(negedge CLK);
    gemm_valid = 0;
    #1;
    total++; if (sp_wen !== 1'b1) begin bad++; $display("FAIL rmid_pre wen=%0b exp=1", sp_wen); end
    nRST = 0;
    #1;
    total++; if (sp_wen !== 1'b0 || busy !== 1'b0 || gemm_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_lost wen=%0b busy=%0b gr=%0b exp 0/0/1", sp_wen, busy, gemm_ready); end
    @(negedge CLK);
    nRST = 1;
    #1;
    total++; if (sp_wen !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_after wen=%0b busy=%0b exp 0/0", sp_wen, busy); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mls_load();
    test_round_robin();
    test_full();
    test_flush();
    test_invalid_ls();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
